dct_row: RTL and testbench
==========================

DCT_ROW -- requirements
Module: dct_row

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  pixels valid.
REQ-005 in_ready  output  1  block can accept a row.
REQ-006 pixels  input  64  eight unsigned 8-bit samples; p[x] = pixels[x*8 +: 8], x=0..7.
REQ-007 out_valid  output  1  coeffs valid.
REQ-008 out_ready  input  1  downstream accepts coeffs.
REQ-009 coeffs  output  128  eight signed 16-bit coefficients; F[u] = coeffs[u*16 +: 16], u=0..7.
REQ-010 busy  output  1  high in COMPUTE state.

Function
REQ-011 SHALL implement an FSM with states IDLE, COMPUTE and DONE.
- IDLE: in_ready=1.
- in_valid&&in_ready at an edge: latch pixels, clear accumulator, set u=0 and x=0, go to COMPUTE.
REQ-012 COMPUTE SHALL perform exactly one MAC per cycle, x inner and u outer, for 64 cycles: acc += (p[x]-128)*T[k] with k=((2x+1)*u) mod 32.
REQ-013 T SHALL be an internal Q10 cosine table.
- T[0..8] = 1024,1004,946,851,724,569,392,200,0.
- T[k] = -T[16-k] for k=9..16.
- T[k] = T[32-k] for k=17..31.
REQ-014 Accumulator SHALL be signed 24-bit; products are signed 9-bit by signed 12-bit.
REQ-015 On the 8th MAC of each u (x=7), the block SHALL:
- write F[u] from the final sum, which includes that term;
- clear the accumulator.
REQ-016 Scaling SHALL use arithmetic right shift (floor):
- F[0] = (sum*362) >>> 20;
- F[u] = sum >>> 11 for u=1..7.
REQ-017 F[u] SHALL saturate to [-2048, 2047] and be sign-extended to 16 bits.
REQ-018 After the 64th MAC edge (E+64, where E is the accepting edge), FSM SHALL enter DONE; out_valid=1 from that edge on. Latency is exactly 64 cycles.
REQ-019 DONE: out_valid SHALL stay high and coeffs SHALL stay stable until out_valid&&out_ready at an edge; then go to IDLE.
REQ-020 in_ready SHALL be 0 in COMPUTE and DONE; a new row is never accepted in the same cycle as output handshake. Minimum period is 66 cycles per row.
REQ-021 Changes on pixels or in_valid outside IDLE SHALL be ignored; changes on out_ready outside DONE SHALL be ignored.
REQ-022 coeffs SHALL hold previous-row values during COMPUTE, updating per u as written.

Reset
REQ-023 rst_n low SHALL immediately force the following, regardless of clock:
- FSM=IDLE; in_ready=1; out_valid=0; busy=0;
- coeffs=0; accumulator, counters and pixel latch = 0.
REQ-024 Reset asserted mid-COMPUTE or in DONE SHALL discard the row. After rst_n rises, the first accept occurs on the first edge with in_valid=1.

Verification
REQ-025 All pixels 128, out_ready=1 -> out_valid 64 cycles after accept; all F[u]=0.
REQ-026 All pixels 255 -> F[0]=359, F[1..7]=0; all pixels 0 -> F[0]=-362, F[1..7]=0.
REQ-027 Ramp p[x]=16x -> each F[u] matches the bit-exact Q10 reference model of REQ-012..017.
REQ-028 out_ready held 0 for 20 cycles after out_valid:
- coeffs and out_valid stay stable, in_ready=0, in_valid pulses ignored;
- on release, IDLE follows; next accept is no earlier than one cycle after handshake.
REQ-029 rst_n pulsed low at MAC cycle 30 with in_valid held high -> outputs return to reset values asynchronously; a fresh row is accepted after release; no stale out_valid occurs.
REQ-030 Back-to-back rows with in_valid and out_ready tied high -> one result per 66 cycles, in order.

Source files
------------

// File: rtl/dct_row_if.sv
// Row-DCT handshake bundle: pixel row in, coefficient row out, plus busy status.
interface dct_row_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  pixels;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] coeffs;
    logic         busy;

    modport slave (
        input  in_valid, pixels, out_ready,
        output in_ready, out_valid, coeffs, busy
    );

    modport master (
        output in_valid, pixels, out_ready,
        input  in_ready, out_valid, coeffs, busy
    );
endinterface

// File: rtl/dct_row.sv
// 8-point 1-D DCT of one pixel row, one multiply-accumulate per cycle (64 cycles/row).
// Q10 cosine table, floor scaling, saturated 12-bit results sign-extended to 16 bits.
module dct_row (
    input  logic       clk,
    input  logic       rst_n,
    dct_row_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             state_q, state_d;
    logic [63:0]        pix_q, pix_d;
    logic signed [23:0] acc_q, acc_d;
    logic [2:0]         u_q, u_d;
    logic [2:0]         x_q, x_d;
    logic [7:0][15:0]   coef_q, coef_d;

    logic [4:0]         k;
    logic signed [11:0] t_k;
    logic signed [8:0]  d_x;
    logic signed [20:0] prod;
    logic signed [23:0] acc_sum;
    logic signed [33:0] sum_ext;
    logic signed [33:0] f0_prod;
    logic signed [33:0] scaled;
    logic [15:0]        f_sat;

    // Cosine table folded onto the first quadrant: T[0..8] plus sign.
    function automatic logic signed [11:0] cos_q10(input logic [4:0] idx);
        logic [3:0]         m;
        logic               neg;
        logic signed [11:0] mag;
        if (idx <= 5'd8) begin
            m   = idx[3:0];
            neg = 1'b0;
        end else if (idx <= 5'd16) begin
            m   = 4'(5'd16 - idx);
            neg = 1'b1;
        end else if (idx <= 5'd23) begin
            m   = 4'(idx - 5'd16);
            neg = 1'b1;
        end else begin
            m   = 4'(6'd32 - {1'b0, idx});
            neg = 1'b0;
        end
        case (m)
            4'd0:    mag = 12'sd1024;
            4'd1:    mag = 12'sd1004;
            4'd2:    mag = 12'sd946;
            4'd3:    mag = 12'sd851;
            4'd4:    mag = 12'sd724;
            4'd5:    mag = 12'sd569;
            4'd6:    mag = 12'sd392;
            4'd7:    mag = 12'sd200;
            default: mag = 12'sd0;
        endcase
        return neg ? -mag : mag;
    endfunction

    always_comb begin
        k       = 5'({x_q, 1'b1}) * 5'(u_q);
        t_k     = cos_q10(k);
        d_x     = $signed({1'b0, pix_q[{x_q, 3'b000} +: 8]}) - 9'sd128;
        prod    = d_x * t_k;
        acc_sum = acc_q + $signed({{3{prod[20]}}, prod});
        sum_ext = $signed({{10{acc_sum[23]}}, acc_sum});
        f0_prod = sum_ext * 34'sd362;
        // DC uses 1/(2*sqrt2) in Q20; AC terms carry a plain 1/2 on top of Q10.
        scaled  = (u_q == 3'd0) ? (f0_prod >>> 20) : (sum_ext >>> 11);
        if (scaled > 34'sd2047)
            f_sat = 16'sd2047;
        else if (scaled < -34'sd2048)
            f_sat = -16'sd2048;
        else
            f_sat = scaled[15:0];
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        acc_d   = acc_q;
        u_d     = u_q;
        x_d     = x_q;
        coef_d  = coef_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pix_d   = bus.pixels;
                    acc_d   = '0;
                    u_d     = '0;
                    x_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                x_d   = x_q + 3'd1;
                acc_d = acc_sum;
                if (x_q == 3'd7) begin
                    coef_d[u_q] = f_sat;
                    acc_d       = '0;
                    u_d         = u_q + 3'd1;
                    if (u_q == 3'd7)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pix_q   <= '0;
            acc_q   <= '0;
            u_q     <= '0;
            x_q     <= '0;
            coef_q  <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            acc_q   <= acc_d;
            u_q     <= u_d;
            x_q     <= x_d;
            coef_q  <= coef_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == COMPUTE);
    assign bus.coeffs    = coef_q;

endmodule

// File: tb/tb_dct_row.sv
// Directed bench for dct_row: latency, hand-computed coefficients, backpressure, reset, streaming.
module tb_dct_row;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dct_row_if bus();

    dct_row u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic signed [15:0] e_zero [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic signed [15:0] e_hi   [8] = '{359, 0, 0, 0, 0, 0, 0, 0};
    logic signed [15:0] e_lo   [8] = '{-362, 0, 0, 0, 0, 0, 0, 0};
    logic signed [15:0] e_ramp [8] = '{-204, -104, 0, -11, 0, -4, 0, -1};

    logic [63:0] p_mid, p_hi, p_lo, p_ramp;

    task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, act, exp);
    endtask

    function automatic logic signed [31:0] fcoef(input int u);
        logic [15:0] f;
        f = bus.coeffs[u*16 +: 16];
        return 32'($signed(f));
    endfunction

    task automatic check_row(input string tag, input logic signed [15:0] exp [8]);
        for (int u = 0; u < 8; u++)
            check($sformatf("%s F%0d", tag, u), fcoef(u), 32'(exp[u]));
    endtask

    // Called at #1 after the accepting edge; counts edges until out_valid.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.out_valid && n < 200);
        check({tag, " latency"}, n, 64);
    endtask

    task automatic send(input logic [63:0] pix, input string tag);
        bus.pixels   = pix;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.pixels   = {$urandom, $urandom};
        check({tag, " busy"}, 32'(bus.busy), 1);
        check({tag, " in_ready"}, 32'(bus.in_ready), 0);
    endtask

    initial begin
        int t_out [3];
        int got_f0 [3];
        int n_out, row_i, c;
        logic prev_busy;
        logic signed [31:0] held_f0;

        p_mid = {8{8'd128}};
        p_hi  = {8{8'd255}};
        p_lo  = {8{8'd0}};
        for (int x = 0; x < 8; x++) p_ramp[x*8 +: 8] = 8'(16 * x);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.pixels    = '0;
        #2;
        check("rst in_ready", 32'(bus.in_ready), 1);
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst busy", 32'(bus.busy), 0);
        check("rst coeffs", 32'(bus.coeffs != 128'd0), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        bus.out_ready = 1'b1;
        send(p_mid, "mid");  wait_out("mid");  check_row("mid", e_zero);
        @(posedge clk); #1;
        check("mid idle", 32'(bus.in_ready), 1);
        send(p_hi, "hi");    wait_out("hi");   check_row("hi", e_hi);
        @(posedge clk); #1;
        send(p_lo, "lo");    wait_out("lo");   check_row("lo", e_lo);
        @(posedge clk); #1;
        send(p_ramp, "ramp"); wait_out("ramp"); check_row("ramp", e_ramp);
        @(posedge clk); #1;

        // Backpressure: output must hold while stray in_valid pulses are ignored.
        bus.out_ready = 1'b0;
        send(p_hi, "bp");
        wait_out("bp");
        held_f0 = fcoef(0);
        check("bp F0", held_f0, 359);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.pixels   = p_lo;
            @(posedge clk); #1;
            check("bp out_valid", 32'(bus.out_valid), 1);
            check("bp in_ready", 32'(bus.in_ready), 0);
            check("bp F0 hold", fcoef(0), held_f0);
        end
        bus.in_valid  = 1'b1;
        bus.pixels    = p_ramp;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs out_valid", 32'(bus.out_valid), 0);
        check("hs in_ready", 32'(bus.in_ready), 1);
        check("hs no accept", 32'(bus.busy), 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("post hs accept", 32'(bus.busy), 1);
        wait_out("post hs");
        check_row("post hs", e_ramp);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a row.
        send(p_hi, "rst row");
        repeat (29) @(posedge clk);
        bus.in_valid = 1'b1;
        bus.pixels   = p_lo;
        #2 rst_n = 1'b0;
        #1;
        check("arst in_ready", 32'(bus.in_ready), 1);
        check("arst busy", 32'(bus.busy), 0);
        check("arst out_valid", 32'(bus.out_valid), 0);
        check("arst coeffs", 32'(bus.coeffs != 128'd0), 0);
        @(posedge clk); #1;
        check("arst held", 32'(bus.busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("arst accept", 32'(bus.busy), 1);
        wait_out("arst");
        check_row("arst", e_lo);
        @(posedge clk); #1;

        // Streaming with in_valid and out_ready tied high.
        n_out        = 0;
        row_i        = 0;
        prev_busy    = 1'b0;
        bus.pixels   = p_hi;
        bus.in_valid = 1'b1;
        c            = 0;
        while (n_out < 3 && c < 400) begin
            @(posedge clk); #1;
            c++;
            if (bus.busy && !prev_busy) begin
                row_i++;
                bus.pixels = (row_i == 1) ? p_lo : p_mid;
            end
            prev_busy = bus.busy;
            if (bus.out_valid) begin
                t_out[n_out]  = c;
                got_f0[n_out] = fcoef(0);
                n_out++;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b count", n_out, 3);
        if (n_out == 3) begin
            check("b2b period 1", t_out[1] - t_out[0], 66);
            check("b2b period 2", t_out[2] - t_out[1], 66);
            check("b2b row0 F0", got_f0[0], 359);
            check("b2b row1 F0", got_f0[1], -362);
            check("b2b row2 F0", got_f0[2], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
